// File: rtl/flag_pkg.sv
// Shared definitions for the flag status unit: flag bit positions,
// condition-code encodings, default save-stack depth and the rule for
// which opcodes are allowed to write the flag register.
package flag_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DEFAULT_STACK_DEPTH = 4;

    localparam logic [3:0] LAST_FLAG_OP = 4'b1010;
    localparam logic [3:0] FLAG_OP_ALL  = 4'b1111;

    typedef enum logic [3:0] {
        COND_AL   = 4'd0,
        COND_EQ   = 4'd1,
        COND_NE   = 4'd2,
        COND_CS   = 4'd3,
        COND_CC   = 4'd4,
        COND_MI   = 4'd5,
        COND_PL   = 4'd6,
        COND_VS   = 4'd7,
        COND_VC   = 4'd8,
        COND_GE   = 4'd9,
        COND_LT   = 4'd10,
        COND_GT   = 4'd11,
        COND_LE   = 4'd12,
        COND_NV13 = 4'd13,
        COND_NV14 = 4'd14,
        COND_NV15 = 4'd15
    } cond_e;

    // Opcodes 0..10 and 15 produce flags; 11..14 are flag-neutral.
    function automatic logic flag_write_allowed(input logic [3:0] opcode);
        return (opcode <= LAST_FLAG_OP) || (opcode == FLAG_OP_ALL);
    endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition evaluator: decides whether a condition
// code is satisfied by a given set of Z/N/C/V flags.
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic z;
    logic n;
    logic c;
    logic v;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition code against the flags; 13..15 never take.
    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_status_unit.sv
// Architectural flag register with a small LIFO save stack, a sticky
// overflow/underflow error and a registered branch-condition result that
// sees the flag value being written on the same edge.
module flag_status_unit
    import flag_pkg::*;
#(
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [3:0] flag_in,
    input  logic       flag_valid,
    input  logic [3:0] cond,
    input  logic       cond_req,
    input  logic       push,
    input  logic       pop,
    input  logic       err_clr,
    output logic [3:0] flags_out,
    output logic       cond_taken,
    output logic       cond_valid,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [3:0]       stack_mem [STACK_DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_minus_one;
    logic [PTR_W-1:0] push_idx;
    logic [PTR_W-1:0] pop_idx;

    logic             write_ok;
    logic             push_only;
    logic             pop_only;
    logic             push_ok;
    logic             pop_ok;
    logic             new_err;
    logic [3:0]       flags_next;
    logic             taken_next;

    assign stack_full      = (count == CNT_W'(STACK_DEPTH));
    assign stack_empty     = (count == '0);
    assign count_minus_one = count - CNT_W'(1);
    assign push_idx        = count[PTR_W-1:0];
    assign pop_idx         = count_minus_one[PTR_W-1:0];

    assign write_ok  = flag_valid & flag_write_allowed(opcode);
    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign push_ok   = push_only & ~stack_full;
    assign pop_ok    = pop_only & ~stack_empty;
    assign new_err   = (push_only & stack_full) | (pop_only & stack_empty);

    // Next flag value: a good pop restores, an erroring stack request
    // freezes the flags, otherwise an allowed write lands.
    always_comb begin
        flags_next = flags_out;
        if (pop_ok) begin
            flags_next = stack_mem[pop_idx];
        end else if (new_err) begin
            flags_next = flags_out;
        end else if (write_ok) begin
            flags_next = flag_in;
        end
    end

    flag_cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags_next),
        .taken (taken_next)
    );

    // Flag register, stack count, sticky error and condition result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_out  <= 4'b0000;
            count      <= '0;
            stack_err  <= 1'b0;
            cond_valid <= 1'b0;
            cond_taken <= 1'b0;
        end else begin
            flags_out  <= flags_next;
            cond_valid <= cond_req;
            if (cond_req) begin
                cond_taken <= taken_next;
            end
            if (push_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok) begin
                count <= count_minus_one;
            end
            if (new_err) begin
                stack_err <= 1'b1;
            end else if (err_clr) begin
                stack_err <= 1'b0;
            end
        end
    end

    // Save-stack storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[push_idx] <= flags_out;
        end
    end

endmodule

// File: tb/tb_flag_status_unit.sv
// Self-checking bench for flag_status_unit: a behavioural model produces
// expected outputs per cycle into a scoreboard queue, each test task pops
// and compares after the clock edge.
module tb_flag_status_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] flags;
        logic       cv;
        logic       ct;
        logic       full;
        logic       empty;
        logic       err;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic [3:0] flag_in;
    logic       flag_valid;
    logic [3:0] cond;
    logic       cond_req;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [3:0] flags_out;
    logic       cond_taken;
    logic       cond_valid;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int checks;
    int failures;

    obs_t       sb [$];
    logic [3:0] m_stack [$];
    logic [3:0] m_flags;
    logic       m_err;
    logic       m_cv;
    logic       m_ct;

    flag_status_unit #(.STACK_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .flag_in     (flag_in),
        .flag_valid  (flag_valid),
        .cond        (cond),
        .cond_req    (cond_req),
        .push        (push),
        .pop         (pop),
        .err_clr     (err_clr),
        .flags_out   (flags_out),
        .cond_taken  (cond_taken),
        .cond_valid  (cond_valid),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic z, n, cy, v;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return !z;
            4'd3:    return cy;
            4'd4:    return !cy;
            4'd5:    return n;
            4'd6:    return !n;
            4'd7:    return v;
            4'd8:    return !v;
            4'd9:    return n == v;
            4'd10:   return n != v;
            4'd11:   return !z && (n == v);
            4'd12:   return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.flags = flags_out;
        o.cv    = cond_valid;
        o.ct    = cond_taken;
        o.full  = stack_full;
        o.empty = stack_empty;
        o.err   = stack_err;
        return o;
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_err   = 1'b0;
        m_cv    = 1'b0;
        m_ct    = 1'b0;
        m_stack.delete();
        sb.delete();
    endtask

    // Drive one cycle of stimulus, advance the model, queue the expectation
    // and return 1 ns after the rising edge.
    task automatic step(input logic [3:0] op, input logic [3:0] fin, input logic fv,
                        input logic [3:0] cnd, input logic cr, input logic ps,
                        input logic pp, input logic clr);
        logic       wr;
        logic       err_now;
        logic [3:0] nf;
        obs_t       e;
        opcode = op; flag_in = fin; flag_valid = fv;
        cond = cnd; cond_req = cr; push = ps; pop = pp; err_clr = clr;
        wr = fv && ((op <= 4'd10) || (op == 4'd15));
        nf = m_flags;
        err_now = 1'b0;
        if (pp && !ps) begin
            if (m_stack.size() == 0) err_now = 1'b1;
            else nf = m_stack.pop_back();
        end else if (ps && !pp) begin
            if (m_stack.size() == DEPTH) begin
                err_now = 1'b1;
            end else begin
                m_stack.push_back(m_flags);
                if (wr) nf = fin;
            end
        end else if (wr) begin
            nf = fin;
        end
        if (err_now) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (cr) m_ct = ref_cond(cnd, nf);
        m_cv = cr;
        m_flags = nf;
        e.flags = m_flags;
        e.cv    = m_cv;
        e.ct    = m_ct;
        e.full  = (m_stack.size() == DEPTH);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        opcode = 4'd0; flag_in = 4'd0; flag_valid = 1'b0; cond = 4'd0;
        cond_req = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (flags_out !== 4'b0000) begin
            failures++; $display("[TB] FAIL reset_flags: got=%b exp=0000", flags_out);
        end
        checks++;
        if (cond_valid !== 1'b0 || cond_taken !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_cond: got cv=%b ct=%b exp 0 0", cond_valid, cond_taken);
        end
        checks++;
        if (stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stack: got empty=%b full=%b err=%b exp 1 0 0",
                     stack_empty, stack_full, stack_err);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_flag_write();
        obs_t got, e;
        logic [3:0] ops [6] = '{4'b0011, 4'b1100, 4'b1111, 4'b1011, 4'b1010, 4'b1110};
        logic [3:0] fis [6] = '{4'b1000, 4'b0001, 4'b0110, 4'b1111, 4'b0101, 4'b0011};
        logic [3:0] req [6] = '{4'b1000, 4'b1000, 4'b0110, 4'b0110, 4'b0101, 4'b0101};
        for (int i = 0; i < 6; i++) begin
            step(ops[i], fis[i], 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            got = observe(); e = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++; $display("[TB] FAIL flag_write_%0d: got=%h exp=%h", i, got, e);
            end
            checks++;
            if (flags_out !== req[i]) begin
                failures++; $display("[TB] FAIL flag_write_const_%0d: got=%b exp=%b", i, flags_out, req[i]);
            end
        end
    endtask

    task automatic test_cond_pair();
        obs_t got, e;
        logic [3:0] cnds [3] = '{4'd9, 4'd10, 4'd0};
        logic       crs  [3] = '{1'b1, 1'b1, 1'b0};
        logic       ects [3] = '{1'b0, 1'b1, 1'b1};
        logic       ecvs [3] = '{1'b1, 1'b1, 1'b0};
        step(4'd0, 4'b0001, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        got = observe(); e = sb.pop_front();
        checks++;
        if (got !== e) begin
            failures++; $display("[TB] FAIL cond_setup: got=%h exp=%h", got, e);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'd0, 4'd0, 1'b0, cnds[i], crs[i], 1'b0, 1'b0, 1'b0);
            got = observe(); e = sb.pop_front();
            checks++;
            if (got !== e || cond_taken !== ects[i] || cond_valid !== ecvs[i]) begin
                failures++;
                $display("[TB] FAIL cond_pair_%0d: got=%h cv=%b ct=%b exp=%h cv=%b ct=%b",
                         i, got, cond_valid, cond_taken, e, ecvs[i], ects[i]);
            end
        end
    endtask

    task automatic test_cond_sweep();
        obs_t got, e;
        logic [3:0] pats [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010,
                                 4'b0001, 4'b0110, 4'b1001, 4'b1111};
        for (int p = 0; p < 8; p++) begin
            step(4'd5, pats[p], 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            void'(sb.pop_front());
            for (int c = 0; c < 16; c++) begin
                step(4'd0, 4'd0, 1'b0, 4'(c), 1'b1, 1'b0, 1'b0, 1'b0);
                got = observe(); e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("[TB] FAIL cond_sweep f=%b c=%0d: got=%h exp=%h", pats[p], c, got, e);
                end
            end
        end
    endtask

    task automatic test_forward();
        obs_t got, e;
        step(4'd0, 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        step(4'd2, 4'b1000, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        got = observe(); e = sb.pop_front();
        checks++;
        if (got !== e || cond_taken !== 1'b1) begin
            failures++; $display("[TB] FAIL forward_write: got=%h ct=%b exp=%h ct=1", got, cond_taken, e);
        end
    endtask

    task automatic test_stack();
        obs_t got, e;
        logic [3:0] wv  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b0011};
        logic [3:0] lifo [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        step(4'd0, 4'b0001, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            step(4'd1, wv[i], 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            got = observe(); e = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++; $display("[TB] FAIL push_%0d: got=%h exp=%h", i, got, e);
            end
        end
        checks++;
        if (stack_full !== 1'b1 || stack_err !== 1'b1 || flags_out !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL overflow: got full=%b err=%b flags=%b exp 1 1 1100",
                     stack_full, stack_err, flags_out);
        end
        for (int i = 0; i < 5; i++) begin
            step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            got = observe(); e = sb.pop_front();
            checks++;
            if (got !== e || (i < 4 && flags_out !== lifo[i])) begin
                failures++; $display("[TB] FAIL pop_%0d: got=%h exp=%h", i, got, e);
            end
        end
        checks++;
        if (stack_empty !== 1'b1 || stack_err !== 1'b1 || flags_out !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL underflow: got empty=%b err=%b flags=%b exp 1 1 0001",
                     stack_empty, stack_err, flags_out);
        end
        // err_clr together with a new underflow keeps the error, then clears.
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        got = observe(); e = sb.pop_front();
        checks++;
        if (got !== e || stack_err !== 1'b1) begin
            failures++; $display("[TB] FAIL clr_vs_err: got=%h exp=%h", got, e);
        end
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = observe(); e = sb.pop_front();
        checks++;
        if (got !== e || stack_err !== 1'b0) begin
            failures++; $display("[TB] FAIL err_clear: got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_push_pop_same();
        obs_t got, e;
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        step(4'd0, 4'b0100, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        got = observe(); e = sb.pop_front();
        checks++;
        if (got !== e || flags_out !== 4'b0100 || stack_err !== 1'b0 ||
            stack_empty !== 1'b0 || stack_full !== 1'b0) begin
            failures++; $display("[TB] FAIL push_pop_same: got=%h exp=%h", got, e);
        end
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        got = observe(); e = sb.pop_front();
        checks++;
        if (got !== e) begin
            failures++; $display("[TB] FAIL push_pop_after: got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0));
            got = observe(); e = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++; $display("[TB] FAIL back_to_back_%0d: got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, e;
        for (int i = 0; i < 2; i++) begin
            step(4'd0, 4'(i + 9), 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        cond = 4'd0; cond_req = 1'b1; push = 1'b1;
        flag_valid = 1'b1; flag_in = 4'b1111; opcode = 4'd0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (flags_out !== 4'b0000 || stack_empty !== 1'b1 || cond_valid !== 1'b0 ||
            stack_full !== 1'b0 || stack_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got flags=%b empty=%b cv=%b exp 0000 1 0",
                     flags_out, stack_empty, cond_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cond_valid !== 1'b0 || flags_out !== 4'b0000) begin
            failures++; $display("[TB] FAIL reset_hold: got cv=%b flags=%b exp 0 0000", cond_valid, flags_out);
        end
        rst_n = 1'b1;
        model_reset();
        idle();
        got = observe(); e = sb.pop_front();
        checks++;
        if (got !== e) begin
            failures++; $display("[TB] FAIL reset_release: got=%h exp=%h", got, e);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_flag_write();
        test_cond_pair();
        test_cond_sweep();
        test_forward();
        test_stack();
        test_push_pop_same();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_status_unit.md
FLAG_STATUS_UNIT -- requirements
Module: flag_status_unit

Interface
REQ-001: Parameter STACK_DEPTH, default 4, SHALL set the number of flag save slots.
REQ-002: Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003: Port rst_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-004: Port opcode, input, 4, SHALL be the ALU opcode accompanying flag_in.
REQ-005: Port flag_in, input, 4, SHALL be the selected ALU flags: [3]=Z, [2]=N, [1]=C, [0]=V.
REQ-006: Port flag_valid, input, 1, SHALL qualify flag_in/opcode as a flag write request.
REQ-007: Port cond, input, 4, SHALL be the branch condition code.
REQ-008: Port cond_req, input, 1, SHALL request evaluation of cond.
REQ-009: Port push, input, 1, SHALL request saving flags_out to the stack.
REQ-010: Port pop, input, 1, SHALL request restoring flags from the stack.
REQ-011: Port err_clr, input, 1, SHALL clear the sticky error.
REQ-012: Port flags_out, output, 4, SHALL be the architectural flag register.
REQ-013: Port cond_taken, output, 1, SHALL be the registered condition result.
REQ-014: Port cond_valid, output, 1, SHALL qualify cond_taken.
REQ-015: Port stack_full, output, 1, SHALL be high when STACK_DEPTH entries are held.
REQ-016: Port stack_empty, output, 1, SHALL be high when no entries are held.
REQ-017: Port stack_err, output, 1, SHALL be a sticky overflow/underflow indicator.

Function
REQ-018: A flag write SHALL occur only when flag_valid=1 and opcode is in 4'b0000-4'b1010 or 4'b1111; opcodes 4'b1011-4'b1110 SHALL leave flags_out unchanged.
REQ-019: A flag write SHALL update flags_out on the next rising edge (1-cycle latency).
REQ-020: Condition codes SHALL be: 0 always; 1 EQ (Z); 2 NE (!Z); 3 CS (C); 4 CC (!C); 5 MI (N); 6 PL (!N); 7 VS (V); 8 VC (!V); 9 GE (N==V); 10 LT (N!=V); 11 GT (!Z & N==V); 12 LE (Z | N!=V); 13-15 never.
REQ-021: cond_taken/cond_valid SHALL be registered one cycle after cond_req; evaluation SHALL use the flag value flags_out will hold after that same edge (same-cycle write/pop forwarded).
REQ-022: cond_valid SHALL be 1 for exactly one cycle per cond_req cycle; cond_taken SHALL hold its last value when cond_valid=0.
REQ-023: push alone and not full SHALL store the current (pre-update) flags_out at the top and increment the count.
REQ-024: pop alone and not empty SHALL load flags_out from the top entry and decrement the count; pop SHALL take priority over a same-cycle flag write.
REQ-025: push when full or pop when empty SHALL leave stack and flags unchanged and set stack_err.
REQ-026: push and pop in the same cycle SHALL be a stack no-op with no error; a same-cycle flag write SHALL still apply.
REQ-027: stack_err SHALL stay set until err_clr=1; a same-cycle err_clr and new error SHALL leave stack_err set.
REQ-028: stack_full/stack_empty SHALL be derived from a count register, valid the cycle after each change.

Reset
REQ-029: rst_n=0 SHALL immediately force flags_out=4'b0000, cond_taken=0, cond_valid=0, stack_err=0, count=0 (stack_empty=1, stack_full=0).
REQ-030: Stack storage contents SHALL NOT require reset; reset mid-operation SHALL discard any in-flight request.

Structure
REQ-031: Flag bit indices, condition-code constants and default STACK_DEPTH SHALL live in a shared package, flag_pkg.
REQ-032: Condition evaluation SHALL be a combinational sub-module, flag_cond_eval (cond, flags -> taken).

Verification
REQ-033: Write opcode 4'b0011, flag_in 4'b1000 -> flags_out 4'b1000 next cycle; opcode 4'b1100, flag_in 4'b0001 -> flags_out stays 4'b1000.
REQ-034: flags 4'b0001 (V only), cond 9 and cond 10 in successive cycles -> cond_taken 0 then 1, cond_valid one pulse each.
REQ-035: Same-cycle write flag_in 4'b1000 and cond_req cond 1 -> cond_taken 1 next cycle.
REQ-036: Push 4 distinct values, 5th push -> stack_full=1, stack_err=1, flags unchanged; 4 pops return values LIFO; 5th pop -> err stays, flags unchanged.
REQ-037: Push+pop with flag write 4'b0100 in one cycle -> count unchanged, flags_out 4'b0100, stack_err 0.
REQ-038: Assert rst_n low mid-stack with cond_req pending -> flags_out 0, stack_empty 1, cond_valid 0 without a clock edge.
